muldiv_sequencer: RTL

- Iterative multi-cycle execution unit for RV32M (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the single-cycle ALU in the execute stage.
- Accepts one operation per start pulse, holds the pipeline with stall while iterating, returns a registered result with a one-cycle done pulse.
- Internally sequences a shift-add / restoring shift-subtract datapath over 32 iterations, with sign pre- and post-correction.

---
 rtl/muldiv_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign correction applied at the end.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_A,
    input  logic [XLEN-1:0] operand_B,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int            CW   = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_mag_q, a_mag_d, b_mag_q, b_mag_d;
    logic              neg_q, neg_d;
    logic              sgn_a_q, sgn_a_d;
    logic              spec_q, spec_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              is_div, a_signed, b_signed, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]   a_in, b_in, spec_val;

    always_comb begin
        is_div   = funct3[2];
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (is_div && !funct3[0]);
        b_signed = (funct3 == 3'b001) || (is_div && !funct3[0]);
        sa       = a_signed & operand_A[XLEN-1];
        sb       = b_signed & operand_B[XLEN-1];
        a_in     = sa ? -operand_A : operand_A;
        b_in     = sb ? -operand_B : operand_B;
        div_zero = is_div && (operand_B == '0);
        div_ovf  = is_div && !funct3[0] && (operand_A == INT_MIN) && (operand_B == '1);
        if (div_zero) spec_val = funct3[1] ? operand_A : '1;
        else          spec_val = funct3[1] ? '0 : INT_MIN;
    end

    // acc holds {product hi, multiplier/product lo} or {remainder, dividend/quotient}
    logic [XLEN:0]     mul_sum, rem_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] step;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
        rem_sh  = acc_q[2*XLEN-1:XLEN-1];
        div_ge  = rem_sh >= {1'b0, b_mag_q};
        div_rem = div_ge ? (rem_sh[XLEN-1:0] - b_mag_q) : rem_sh[XLEN-1:0];
        if (op_q[2]) step = {div_rem, acc_q[XLEN-2:0], div_ge};
        else         step = {mul_sum, acc_q[XLEN-1:1]};
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, sel;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = sgn_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 sel = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: sel = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         sel = quo_fix;
            default:                sel = rem_fix;
        endcase
        if (spec_q) sel = acc_q[XLEN-1:0];
    end

    // Special cases park their answer in acc and skip the iterations via count=LAST
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        neg_d    = neg_q;
        sgn_a_d  = sgn_a_q;
        spec_d   = spec_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    op_d    = funct3;
                    a_mag_d = a_in;
                    b_mag_d = b_in;
                    neg_d   = sa ^ sb;
                    sgn_a_d = sa;
                    if (div_zero || div_ovf) begin
                        spec_d  = 1'b1;
                        count_d = LAST;
                        acc_d   = {{XLEN{1'b0}}, spec_val};
                    end else begin
                        spec_d  = 1'b0;
                        count_d = '0;
                        acc_d   = {{XLEN{1'b0}}, (is_div ? a_in : b_in)};
                    end
                end
            end
            CALC: begin
                if (count_q == LAST) begin
                    state_d  = FINISH;
                    result_d = sel;
                end else begin
                    acc_d   = step;
                    count_d = count_q + CW'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= '0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            neg_q    <= 1'b0;
            sgn_a_q  <= 1'b0;
            spec_q   <= 1'b0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            neg_q    <= neg_d;
            sgn_a_q  <= sgn_a_d;
            spec_q   <= spec_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign stall  = (state_q == CALC) || ((state_q == IDLE) && start);

endmodule
